// File: rtl/aes_round_engine_if.sv
// aes_round_engine_if: start/data/key-schedule handshake between a requester and the AES round engine
interface aes_round_engine_if #(parameter int nb = 4, parameter int nr = 10);
  logic start;
  logic [127:0] data_in;
  logic [32*nb*(nr+1)-1:0] w;
  logic [127:0] data_out;
  logic busy;
  logic done;
  modport master (output start, data_in, w, input data_out, busy, done);
  modport slave (input start, data_in, w, output data_out, busy, done);
endinterface

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryptor, one round per clock, keyed from an external expanded schedule
module aes_sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  localparam logic [2047:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // entry x sits at bit 2047-8x, i.e. {~x, 3'b111}
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return sbox_tbl[{~x, 3'b111} -: 8];
  endfunction
  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]), sbox(word_i[15:8]), sbox(word_i[7:0])};
endmodule

module aes_round_engine #(
  parameter int nk = 4,
  parameter int nb = 4,
  parameter int nr = 10
) (
  input logic clk,
  input logic rst,
  aes_round_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_e;
  localparam logic [3:0] last_round = 4'(nr - 1);
  if (nb != 4 || !((nk == 4 && nr == 10) || (nk == 6 && nr == 12) || (nk == 8 && nr == 14))) begin : g_bad_cfg
    $error("aes_round_engine: unsupported nk/nb/nr combination");
  end
  fsm_e fsm_q;
  logic [127:0] state_q, data_out_q;
  logic [3:0] cnt_q;
  logic busy_q, done_q;
  logic [127:0] sb, sr, mc, rk_sel;
  logic [127:0] rk [nr+1];
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  for (genvar i = 0; i <= nr; i++) begin : g_rk
    assign rk[i] = bus.w[128*i +: 128];
  end
  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_sub_word u_sub (.word_i(state_q[32*c +: 32]), .word_o(sb[32*c +: 32]));
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[32*c+24-8*r +: 8] = sb[32*((c+r)%4)+24-8*r +: 8];
    end
    assign mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
  end
  assign rk_sel = rk[cnt_q];
  assign bus.data_out = data_out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      state_q <= '0;
      data_out_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: if (bus.start) begin
          state_q <= bus.data_in ^ rk[0];
          cnt_q <= 4'd1;
          busy_q <= 1'b1;
          fsm_q <= (nr == 1) ? FINAL : ROUND;
        end
        ROUND: begin
          state_q <= mc ^ rk_sel;
          cnt_q <= cnt_q + 4'd1;
          fsm_q <= (cnt_q == last_round) ? FINAL : ROUND;
        end
        FINAL: begin
          data_out_q <= sr ^ rk_sel;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end
endmodule
